// File: rtl/xnorseq_pkg.sv
// Shared types and width helpers for the XNOR-popcount neuron sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: the sequencer state enum and constant functions that derive
// CNT_MAX / POP_W / ACC_W from POP_SIZE and MAX_CHUNKS.
// Optional feature macro: XNORSEQ_MAJ_EN (3-bit majority before popcount).
package xnorseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Largest count a single chunk can produce.
  function automatic int cnt_max(input int pop_size);
`ifdef XNORSEQ_MAJ_EN
    return pop_size / 3;
`else
    return pop_size;
`endif
  endfunction

  // +1 so that a count equal to a power of two still fits.
  function automatic int pop_w(input int pop_size);
    return $clog2(cnt_max(pop_size) + 1);
  endfunction

  function automatic int acc_w(input int pop_size, input int max_chunks);
    return $clog2(cnt_max(pop_size) * max_chunks + 1);
  endfunction

endpackage

// File: rtl/xnorpop_count.sv
// XNOR match + optional 3-bit majority vote + popcount of one chunk.
// Latency: 0 cycles (purely combinational; the caller registers the result).
// Backpressure: none, no handshake.
//
// Ports:
//   a, w       POP_SIZE-bit activation and weight chunk
//   pop_count  number of matching bits (or majority groups), POP_W bits
// Optional feature macro: XNORSEQ_MAJ_EN -- count 3-bit groups with a
// majority of matches instead of individual matching bits.
module xnorpop_count
  import xnorseq_pkg::*;
#(
  parameter int POP_SIZE = 576
) (
  input  logic [POP_SIZE-1:0]           a,
  input  logic [POP_SIZE-1:0]           w,
  output logic [pop_w(POP_SIZE)-1:0]    pop_count
);

  localparam int CNT_MAX = cnt_max(POP_SIZE);
  localparam int POP_W   = pop_w(POP_SIZE);

  logic [POP_SIZE-1:0] match;
  logic [CNT_MAX-1:0]  cnt_bits;

  assign match = ~(a ^ w);

`ifdef XNORSEQ_MAJ_EN
  // Group g covers match bits 3g..3g+2; it counts when at least two agree.
  always_comb begin
    cnt_bits = '0;
    for (int g = 0; g < CNT_MAX; g++) begin
      cnt_bits[g] = (match[3*g]   & match[3*g+1]) |
                    (match[3*g]   & match[3*g+2]) |
                    (match[3*g+1] & match[3*g+2]);
    end
  end
`else
  assign cnt_bits = match;
`endif

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < CNT_MAX; i++) begin
      pop_count = pop_count + POP_W'(cnt_bits[i]);
    end
  end

endmodule

// File: rtl/xnorpop_seq.sv
// Binary-neuron sequencer: streams cfg_len chunks, accumulates XNOR-popcounts, thresholds the total.
// Latency: last accepted chunk to out_valid is 2 cycles; cfg_len=0 gives out_valid the cycle after start.
// Backpressure: in_ready only in LOAD (one chunk/cycle); result held on out_* until out_valid & out_ready.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   start, cfg_len,
//   cfg_thresh               job launch; length/threshold latched in IDLE
//   busy                     high whenever the sequencer is not idle
//   in_valid/in_ready,
//   in_a, in_w               chunk stream (activation, weight)
//   out_valid/out_ready,
//   out_sum, out_bit         accumulated count and out_sum >= threshold
// Optional feature macro: XNORSEQ_MAJ_EN (majority-of-3 counting, narrower widths).
module xnorpop_seq
  import xnorseq_pkg::*;
#(
  parameter int POP_SIZE   = 576,
  parameter int MAX_CHUNKS = 16,
  parameter int LEN_W      = $clog2(MAX_CHUNKS + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [LEN_W-1:0]                      cfg_len,
  input  logic [acc_w(POP_SIZE, MAX_CHUNKS)-1:0] cfg_thresh,
  output logic                                  busy,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [POP_SIZE-1:0]                   in_a,
  input  logic [POP_SIZE-1:0]                   in_w,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [acc_w(POP_SIZE, MAX_CHUNKS)-1:0] out_sum,
  output logic                                  out_bit
);

  localparam int               POP_W   = pop_w(POP_SIZE);
  localparam int               ACC_W   = acc_w(POP_SIZE, MAX_CHUNKS);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_CHUNKS);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [ACC_W-1:0] thresh_q;
  logic [ACC_W-1:0] acc;
  logic [POP_W-1:0] pop_q;
  logic [POP_W-1:0] pop_d;
  logic             pop_v;

  logic [LEN_W-1:0] len_sat;
  logic             beat;
  logic             last_beat;

  xnorpop_count #(
    .POP_SIZE (POP_SIZE)
  ) u_count (
    .a         (in_a),
    .w         (in_w),
    .pop_count (pop_d)
  );

  // Oversized lengths clamp instead of wrapping the beat counter.
  assign len_sat   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  // in_ready is a registered copy of "state == LOAD".
  assign beat      = in_valid & in_ready;
  assign last_beat = beat & (beat_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      thresh_q  <= '0;
      beat_cnt  <= '0;
      acc       <= '0;
      pop_q     <= '0;
      pop_v     <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // pop_v is a one-cycle strobe per accepted chunk.
      pop_v <= 1'b0;
      if (pop_v) begin
        acc <= acc + ACC_W'(pop_q);
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len_sat;
            thresh_q <= cfg_thresh;
            acc      <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (len_sat == '0) begin
              state     <= OUT;
              out_valid <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (beat) begin
            pop_q    <= pop_d;
            pop_v    <= 1'b1;
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end

        // The last count is being added on this edge, so acc is final
        // when OUT is entered.
        DRAIN: begin
          if (pop_v) begin
            state     <= OUT;
            out_valid <= 1'b1;
          end
        end

        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // acc and thresh_q are frozen in OUT, so these hold steady while stalled.
  assign out_sum = out_valid ? acc : '0;
  assign out_bit = out_valid & (acc >= thresh_q);

endmodule
